// File: rtl/nv_nvdla_cacc_pkg.sv
// -----------------------------------------------------------------------------
// nv_nvdla_cacc_pkg
// Shared definitions for the CACC mac2accu receive front:
//   - side-band pd bit positions
//   - sequencing FSM state encoding
//   - beat record stored in the receive FIFO
//   - saturating 16-bit increment used by the stripe counter
// -----------------------------------------------------------------------------
package nv_nvdla_cacc_pkg;

  localparam int CACC_ATOMK_HALF   = 8;
  localparam int CACC_RESULT_WIDTH = 19;
  localparam int CACC_PD_W         = 9;

  localparam int PD_STRIPE_ST   = 0;
  localparam int PD_STRIPE_END  = 1;
  localparam int PD_CHANNEL_END = 2;
  localparam int PD_LAYER_END   = 3;
  localparam int PD_BATCH_LSB   = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    IN_STRIPE  = 2'd1,
    STRIPE_GAP = 2'd2,
    LAYER_END  = 2'd3
  } rx_state_e;

  // Field widths follow the package constants; the top-level parameters are
  // expected to stay at these defaults.
  typedef struct packed {
    logic [CACC_ATOMK_HALF*CACC_RESULT_WIDTH-1:0] data;
    logic [CACC_ATOMK_HALF-1:0]                   mask;
    logic                                         mode;
    logic [CACC_PD_W-1:0]                         pd;
  } mac_beat_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/nv_nvdla_cacc_mac_rx_fifo.sv
// -----------------------------------------------------------------------------
// nv_nvdla_cacc_mac_rx_fifo
// DEPTH-entry register FIFO of mac_beat_t records. The head entry is read
// straight out of the storage registers, so a write in cycle N is visible at
// the earliest in cycle N+1. The caller guarantees push_i is only raised when
// the FIFO is not full or a pop happens in the same cycle.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   push_i, wdata_i     write strobe and beat
//   pop_i               read strobe (only while !empty_o)
//   rdata_o             head beat
//   full_o, empty_o     occupancy flags
// -----------------------------------------------------------------------------
module nv_nvdla_cacc_mac_rx_fifo
  import nv_nvdla_cacc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  mac_beat_t wdata_i,
  input  logic      pop_i,
  output mac_beat_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  mac_beat_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/nv_nvdla_cacc_mac_rx.sv
// -----------------------------------------------------------------------------
// nv_nvdla_cacc_mac_rx
// Receive front of CACC for the mac2accu interface. Every valid input beat
// (no backpressure upstream) has its unmasked lanes zeroed and is queued in an
// elastic FIFO, then offered to the accumulator over rx2acc valid/ready.
// A push-side FSM tracks stripe/layer sequencing, pulses layer_done with the
// stripe count of the finished layer, and flags sequencing/overflow errors.
// Optional feature macro: NVDLA_CACC_MAC_RX_ERR_EN enables the sticky error
// flags and err_clr; without it err_seq/err_ovf read 0 and overflowing beats
// are still dropped.
// Ports:
//   nvdla_core_clk, nvdla_core_rstn     clock, async active-low reset
//   mac2accu_pvld/mask/mode/data/pd     input beat
//   rx2acc_valid/ready/data/mask/mode/pd  output beat handshake
//   layer_done, stripe_cnt              end-of-layer pulse and stripe count
//   err_seq, err_ovf, err_clr           sticky errors and their clear
// -----------------------------------------------------------------------------
module nv_nvdla_cacc_mac_rx
  import nv_nvdla_cacc_pkg::*;
#(
  parameter int ATOMK_HALF   = CACC_ATOMK_HALF,
  parameter int RESULT_WIDTH = CACC_RESULT_WIDTH,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               nvdla_core_clk,
  input  logic                               nvdla_core_rstn,
  input  logic                               mac2accu_pvld,
  input  logic [ATOMK_HALF-1:0]              mac2accu_mask,
  input  logic                               mac2accu_mode,
  input  logic [ATOMK_HALF*RESULT_WIDTH-1:0] mac2accu_data,
  input  logic [8:0]                         mac2accu_pd,
  output logic                               rx2acc_valid,
  input  logic                               rx2acc_ready,
  output logic [ATOMK_HALF*RESULT_WIDTH-1:0] rx2acc_data,
  output logic [ATOMK_HALF-1:0]              rx2acc_mask,
  output logic                               rx2acc_mode,
  output logic [8:0]                         rx2acc_pd,
  output logic                               layer_done,
  output logic [15:0]                        stripe_cnt,
  output logic                               err_seq,
  output logic                               err_ovf,
  input  logic                               err_clr
);

  mac_beat_t wbeat_s;
  mac_beat_t rbeat_s;
  logic      full_s;
  logic      empty_s;
  logic      pop_s;
  logic      accept_s;
  logic      ovf_s;

  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign pop_s    = rx2acc_valid && rx2acc_ready;
  assign accept_s = mac2accu_pvld && (!full_s || pop_s);
  assign ovf_s    = mac2accu_pvld && full_s && !pop_s;

  // Lane masking and packing of the incoming beat.
  always_comb begin
    wbeat_s = '0;
    for (int k = 0; k < ATOMK_HALF; k++) begin
      wbeat_s.data[k*RESULT_WIDTH +: RESULT_WIDTH] =
        mac2accu_data[k*RESULT_WIDTH +: RESULT_WIDTH] & {RESULT_WIDTH{mac2accu_mask[k]}};
    end
    wbeat_s.mask = mac2accu_mask;
    wbeat_s.mode = mac2accu_mode;
    wbeat_s.pd   = mac2accu_pd;
  end

  nv_nvdla_cacc_mac_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (nvdla_core_clk),
    .rst_ni  (nvdla_core_rstn),
    .push_i  (accept_s),
    .wdata_i (wbeat_s),
    .pop_i   (pop_s),
    .rdata_o (rbeat_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign rx2acc_valid = !empty_s;
  assign rx2acc_data  = rbeat_s.data;
  assign rx2acc_mask  = rbeat_s.mask;
  assign rx2acc_mode  = rbeat_s.mode;
  assign rx2acc_pd    = rbeat_s.pd;

  // ---------------------------------------------------------------------------
  // Sequencing FSM (push side, accepted beats only)
  // ---------------------------------------------------------------------------
  rx_state_e   state_q, state_d, eff_s;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] stripe_cnt_q;
  logic        layer_done_q;
  logic        seq_err_s;
  logic        pd_st_s, pd_end_s, pd_lend_s;

  assign pd_st_s   = mac2accu_pd[PD_STRIPE_ST];
  assign pd_end_s  = mac2accu_pd[PD_STRIPE_END];
  assign pd_lend_s = mac2accu_pd[PD_LAYER_END];

  // Next-state logic. LAYER_END lasts one cycle; a beat in that cycle is
  // judged as if the FSM were already back in IDLE with a cleared counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_err_s = 1'b0;
    eff_s     = state_q;
    if (state_q == LAYER_END) begin
      eff_s   = IDLE;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      eff_s   = state_q;
    end
    if (accept_s) begin
      if ((eff_s == IN_STRIPE) || pd_st_s) begin
        // stripe_st inside a stripe restarts it but is still an error
        if ((eff_s == IN_STRIPE) && pd_st_s) begin
          seq_err_s = 1'b1;
        end else begin
          seq_err_s = 1'b0;
        end
        if (pd_end_s) begin
          cnt_d   = sat_inc16(cnt_d);
          state_d = pd_lend_s ? LAYER_END : STRIPE_GAP;
        end else if (pd_lend_s) begin
          seq_err_s = 1'b1;
          state_d   = LAYER_END;
        end else begin
          state_d   = IN_STRIPE;
        end
      end else begin
        // beat outside a stripe: still stored, state held
        seq_err_s = 1'b1;
        state_d   = eff_s;
      end
    end else begin
      seq_err_s = 1'b0;
    end
  end

  // FSM state, stripe counter and registered layer_done/stripe_cnt.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      layer_done_q <= 1'b0;
      stripe_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      layer_done_q <= (state_d == LAYER_END);
      if (state_d == LAYER_END) begin
        stripe_cnt_q <= cnt_d;
      end
    end
  end

  assign layer_done = layer_done_q;
  assign stripe_cnt = stripe_cnt_q;

`ifdef NVDLA_CACC_MAC_RX_ERR_EN
  logic err_seq_q;
  logic err_ovf_q;

  // Sticky error flags; a new error wins over a coincident clear.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      err_seq_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      err_seq_q <= seq_err_s ? 1'b1 : (err_clr ? 1'b0 : err_seq_q);
      err_ovf_q <= ovf_s     ? 1'b1 : (err_clr ? 1'b0 : err_ovf_q);
    end
  end

  assign err_seq = err_seq_q;
  assign err_ovf = err_ovf_q;
`else
  logic unused_err_s;
  assign unused_err_s = ^{err_clr, seq_err_s, ovf_s};
  assign err_seq      = 1'b0;
  assign err_ovf      = 1'b0;
`endif

endmodule
